// File: rtl/gpio_bank_controller.sv
// Memory-mapped GPIO bank: output/direction registers, atomic SET/CLR/TGL writes,
// synchronised pin inputs and per-pin edge interrupts with sticky W1C status.
module gpio_bank_controller #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           GPIO_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h1001_0024),
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr_ram,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  enable_sw,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq,
  output logic                  demuxSelector
);

  localparam int unsigned REG_COUNT = 9;
  localparam int unsigned IDX_WIDTH = 4;

  typedef enum logic [IDX_WIDTH-1:0] {
    REG_OUT        = 4'd0,
    REG_SET        = 4'd1,
    REG_CLR        = 4'd2,
    REG_TGL        = 4'd3,
    REG_DIR        = 4'd4,
    REG_IN         = 4'd5,
    REG_IRQ_EN     = 4'd6,
    REG_IRQ_POL    = 4'd7,
    REG_IRQ_STATUS = 4'd8
  } reg_idx_e;

  logic [ADDR_WIDTH-1:0] offset;
  logic                  hit;
  reg_idx_e              idx;
  logic                  wr_en;
  logic [GPIO_WIDTH-1:0] wbits;

  logic [GPIO_WIDTH-1:0] out_q, out_d;
  logic [GPIO_WIDTH-1:0] dir_q, dir_d;
  logic [GPIO_WIDTH-1:0] irq_en_q, irq_en_d;
  logic [GPIO_WIDTH-1:0] irq_pol_q, irq_pol_d;
  logic [GPIO_WIDTH-1:0] irq_status_q, irq_status_d;
  logic [GPIO_WIDTH-1:0] w1c_mask;
  logic                  demux_q;

  logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_WIDTH-1:0] in_sync;
  logic [GPIO_WIDTH-1:0] in_prev_q;
  logic [GPIO_WIDTH-1:0] rise;
  logic [GPIO_WIDTH-1:0] fall;
  logic [GPIO_WIDTH-1:0] edge_event;
  logic [GPIO_WIDTH-1:0] rd_bits;

  // Address decode: exact word hits only; addresses below BASE_ADDR wrap high and miss.
  assign offset = addr_ram - BASE_ADDR;
  assign hit    = (offset[1:0] == 2'b00) && (offset < ADDR_WIDTH'(REG_COUNT * 4));
  assign idx    = reg_idx_e'(offset[IDX_WIDTH+1:2]);
  assign wr_en  = enable_sw && hit;
  assign wbits  = wdata[GPIO_WIDTH-1:0];

  // Upper write-data bits carry no register state.
  if (DATA_WIDTH > GPIO_WIDTH) begin : g_wdata_upper
    logic unused_wdata_upper;
    assign unused_wdata_upper = ^wdata[DATA_WIDTH-1:GPIO_WIDTH];
  end

  // Edge detection on the synchronised pins; output pins never raise status.
  assign in_sync    = sync_q[SYNC_STAGES-1];
  assign rise       = in_sync & ~in_prev_q;
  assign fall       = ~in_sync & in_prev_q;
  assign edge_event = ((irq_pol_q & rise) | (~irq_pol_q & fall)) & irq_en_q & ~dir_q;

  // Register next-state; a same-cycle edge event wins over a W1C of that bit.
  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    irq_en_d  = irq_en_q;
    irq_pol_d = irq_pol_q;
    w1c_mask  = '0;
    if (wr_en) begin
      case (idx)
        REG_OUT:        out_d     = wbits;
        REG_SET:        out_d     = out_q | wbits;
        REG_CLR:        out_d     = out_q & ~wbits;
        REG_TGL:        out_d     = out_q ^ wbits;
        REG_DIR:        dir_d     = wbits;
        REG_IRQ_EN:     irq_en_d  = wbits;
        REG_IRQ_POL:    irq_pol_d = wbits;
        REG_IRQ_STATUS: w1c_mask  = wbits;
        default:        ;
      endcase
    end
    irq_status_d = edge_event | (irq_status_q & ~w1c_mask);
  end

  // Combinational read mux; write-only strobes and misses read as zero.
  always_comb begin
    rd_bits = '0;
    if (hit) begin
      case (idx)
        REG_OUT:        rd_bits = out_q;
        REG_DIR:        rd_bits = dir_q;
        REG_IN:         rd_bits = in_sync;
        REG_IRQ_EN:     rd_bits = irq_en_q;
        REG_IRQ_POL:    rd_bits = irq_pol_q;
        REG_IRQ_STATUS: rd_bits = irq_status_q;
        default:        rd_bits = '0;
      endcase
    end
  end

  assign rdata = DATA_WIDTH'(rd_bits);

  // Pin synchroniser chain plus one-cycle history for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      in_prev_q <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      in_prev_q <= in_sync;
    end
  end

  // Control/status register state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q        <= '0;
      dir_q        <= '0;
      irq_en_q     <= '0;
      irq_pol_q    <= '0;
      irq_status_q <= '0;
      demux_q      <= 1'b0;
    end else begin
      out_q        <= out_d;
      dir_q        <= dir_d;
      irq_en_q     <= irq_en_d;
      irq_pol_q    <= irq_pol_d;
      irq_status_q <= irq_status_d;
      demux_q      <= demux_q | wr_en;
    end
  end

  assign gpio_out      = out_q;
  assign gpio_oe       = dir_q;
  assign irq           = |irq_status_q;
  assign demuxSelector = demux_q;

endmodule

// File: tb/tb_gpio_bank_controller.sv
// Scoreboard bench for gpio_bank_controller: a register-level reference model predicts
// every cycle's outputs; a negedge monitor pops and compares them.
module tb_gpio_bank_controller;

  localparam int unsigned SS   = 2;
  localparam logic [31:0] BASE = 32'h1001_0024;

  localparam logic [31:0] O_OUT  = 32'h00;
  localparam logic [31:0] O_SET  = 32'h04;
  localparam logic [31:0] O_CLR  = 32'h08;
  localparam logic [31:0] O_TGL  = 32'h0C;
  localparam logic [31:0] O_DIR  = 32'h10;
  localparam logic [31:0] O_IN   = 32'h14;
  localparam logic [31:0] O_EN   = 32'h18;
  localparam logic [31:0] O_POL  = 32'h1C;
  localparam logic [31:0] O_STAT = 32'h20;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr_ram;
  logic [31:0] wdata;
  logic        enable_sw;
  logic [31:0] rdata;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_oe;
  logic        irq;
  logic        demux_sel;

  gpio_bank_controller dut (
    .clk          (clk),
    .reset        (reset),
    .addr_ram     (addr_ram),
    .wdata        (wdata),
    .enable_sw    (enable_sw),
    .rdata        (rdata),
    .gpio_in      (gpio_in),
    .gpio_out     (gpio_out),
    .gpio_oe      (gpio_oe),
    .irq          (irq),
    .demuxSelector(demux_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [7:0]  out;
    logic [7:0]  oe;
    logic        irq;
    logic        demux;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model state, named after the programmer-visible registers.
  logic [7:0] m_out, m_dir, m_en, m_pol, m_stat, m_prev;
  logic       m_demux;
  logic [7:0] m_pipe [SS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_out = '0; m_dir = '0; m_en = '0; m_pol = '0; m_stat = '0; m_prev = '0;
    m_demux = 1'b0;
    for (int s = 0; s < SS; s++) m_pipe[s] = '0;
  endtask

  function automatic logic model_hit(input logic [31:0] a, output int k);
    logic [31:0] off;
    off = a - BASE;
    k   = int'(off / 4);
    return (off % 4 == 0) && (off <= 32'h20);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int k;
    if (!model_hit(a, k)) return 32'h0;
    case (k)
      0: return 32'(m_out);
      4: return 32'(m_dir);
      5: return 32'(m_pipe[SS-1]);
      6: return 32'(m_en);
      7: return 32'(m_pol);
      8: return 32'(m_stat);
      default: return 32'h0;
    endcase
  endfunction

  // One rising edge of the model, using the inputs presented during the cycle.
  task automatic model_edge(input logic en, input logic [31:0] a, input logic [31:0] d);
    logic [7:0] cur, b, nstat;
    int k;
    logic hit;
    cur   = m_pipe[SS-1];
    b     = d[7:0];
    hit   = model_hit(a, k);
    nstat = m_stat;
    for (int i = 0; i < 8; i++) begin
      logic rose, fell, trig;
      rose = cur[i] && !m_prev[i];
      fell = !cur[i] && m_prev[i];
      trig = m_pol[i] ? rose : fell;
      if (en && hit && k == 8 && b[i]) nstat[i] = 1'b0;
      if (trig && m_en[i] && !m_dir[i]) nstat[i] = 1'b1;
    end
    if (en && hit) begin
      m_demux = 1'b1;
      case (k)
        0: m_out = b;
        1: m_out = m_out | b;
        2: m_out = m_out & ~b;
        3: m_out = m_out ^ b;
        4: m_dir = b;
        6: m_en  = b;
        7: m_pol = b;
        default: ;
      endcase
    end
    m_stat = nstat;
    m_prev = cur;
    for (int s = SS - 1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
    m_pipe[0] = gpio_in;
  endtask

  // One bus cycle: present inputs, record the expectation, advance model on the edge.
  task automatic cycle(input logic en, input logic [31:0] off, input logic [31:0] d);
    exp_t e;
    enable_sw = en;
    addr_ram  = BASE + off;
    wdata     = d;
    e.rdata   = model_read(addr_ram);
    e.out     = m_out;
    e.oe      = m_dir;
    e.irq     = |m_stat;
    e.demux   = m_demux;
    exp_q.push_back(e);
    @(posedge clk);
    model_edge(en, addr_ram, d);
    #1;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    cycle(1'b1, off, d);
  endtask

  task automatic rd(input logic [31:0] off);
    cycle(1'b0, off, 32'hDEAD_BEEF);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, O_OUT, 32'h0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("rdata", rdata, mon_e.rdata);
      chk("gpio_out", 32'(gpio_out), 32'(mon_e.out));
      chk("gpio_oe", 32'(gpio_oe), 32'(mon_e.oe));
      chk("irq", 32'(irq), 32'(mon_e.irq));
      chk("demuxSelector", 32'(demux_sel), 32'(mon_e.demux));
    end
  end

  initial begin
    reset = 1'b0; enable_sw = 1'b0; addr_ram = BASE; wdata = '0; gpio_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_gpio_out", 32'(gpio_out), 32'h0);
    chk("reset_gpio_oe", 32'(gpio_oe), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_demux", 32'(demux_sel), 32'h0);
    chk("reset_rdata_out", rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // OUT / CLR / TGL sequence and write-only strobes reading zero.
    wr(O_OUT, 32'hFFFF_FFA5);
    wr(O_CLR, 32'h0F);
    wr(O_TGL, 32'h03);
    rd(O_SET); rd(O_CLR); rd(O_TGL); rd(O_OUT);
    wr(O_SET, 32'h0); wr(O_SET, 32'h40); wr(O_CLR, 32'h40);
    rd(O_OUT);

    // Rising-edge interrupt on bit 0, then W1C.
    wr(O_DIR, 32'h00); wr(O_EN, 32'h01); wr(O_POL, 32'h01);
    gpio_in[0] = 1'b1;
    idle(4);
    rd(O_STAT); rd(O_IN);
    wr(O_STAT, 32'h01);
    idle(1); rd(O_STAT);

    // Falling-edge interrupt on bit 3; masked when bit 3 is an output.
    wr(O_POL, 32'h00); wr(O_EN, 32'h08);
    gpio_in[3] = 1'b1; idle(4);
    gpio_in[3] = 1'b0; idle(4);
    rd(O_STAT);
    wr(O_STAT, 32'h08);
    wr(O_DIR, 32'h08);
    gpio_in[3] = 1'b1; idle(4);
    gpio_in[3] = 1'b0; idle(4);
    rd(O_STAT);

    // W1C landing on the same edge as a new event keeps the bit set.
    wr(O_DIR, 32'h00); wr(O_EN, 32'h01); wr(O_POL, 32'h01);
    gpio_in[0] = 1'b0; idle(4);
    gpio_in[0] = 1'b1; idle(4);
    gpio_in[0] = 1'b0; idle(4);
    gpio_in[0] = 1'b1;
    idle(2);
    wr(O_STAT, 32'h01);
    rd(O_STAT);

    // Asynchronous reset while irq is pending and OUT = 0xFF.
    wr(O_OUT, 32'hFF);
    rd(O_OUT);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    chk("async_rst_gpio_out", 32'(gpio_out), 32'h0);
    chk("async_rst_gpio_oe", 32'(gpio_oe), 32'h0);
    chk("async_rst_irq", 32'(irq), 32'h0);
    chk("async_rst_demux", 32'(demux_sel), 32'h0);
    chk("async_rst_rdata", rdata, 32'h0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;

    // Off-map and misaligned writes are ignored.
    wr(32'h24, 32'hFF);
    wr(32'h02, 32'hFF);
    wr(32'hFFFF_FFFC, 32'hFF);
    rd(32'h24); rd(32'h02); rd(O_OUT); rd(O_DIR);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      int unsigned r;
      if ($urandom_range(0, 2) == 0) gpio_in = gpio_in ^ 8'($urandom);
      r = $urandom_range(0, 9);
      if (r <= 5)      cycle(1'b1, 32'($urandom_range(0, 10)) * 4, $urandom);
      else if (r <= 8) cycle(1'b0, 32'($urandom_range(0, 10)) * 4, $urandom);
      else             cycle($urandom_range(0, 1) == 1, 32'($urandom_range(0, 40)), $urandom);
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
